// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and defaults for the multi-port SRAM arbiter.
package sram_port_arbiter_pkg;

    localparam int unsigned DefaultAccessCycles = 2;
    localparam int unsigned DefaultAddrWidth    = 20;
    localparam int unsigned DefaultDataWidth    = 32;

    typedef logic [DefaultAddrWidth-1:0] SramAddress;
    typedef logic [DefaultDataWidth-1:0] SramData;

    typedef enum logic {
        StIdle,
        StAccess
    } arb_state_e;

endpackage

// File: rtl/sram_port_arbiter_rr_priority_picker.sv
// Combinational winner selection: real-time index first, then round-robin from ptr
// or lowest-index-first, returned as a one-hot grant.
module rr_priority_picker #(
    parameter int unsigned NUM_REQ   = 3,
    parameter int unsigned PTR_WIDTH = 2,
    parameter int unsigned RR_MODE   = 1,
    parameter int unsigned RT_INDEX  = 0
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [PTR_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]   grant
);

    localparam int unsigned PosW = PTR_WIDTH + 1;

    always_comb begin
        logic [PosW-1:0] pos;
        logic            found;
        grant = '0;
        found = 1'b0;
        pos   = '0;
        if (req[RT_INDEX]) begin
            grant[RT_INDEX] = 1'b1;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (RR_MODE != 0) begin
                    // ptr + i never reaches 2*NUM_REQ, so one conditional wrap suffices
                    pos = {1'b0, ptr} + PosW'(i);
                    if (pos >= PosW'(NUM_REQ)) begin
                        pos = pos - PosW'(NUM_REQ);
                    end
                end else begin
                    pos = PosW'(i);
                end
                if (!found && req[pos[PTR_WIDTH-1:0]]) begin
                    grant[pos[PTR_WIDTH-1:0]] = 1'b1;
                    found                     = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Arbitrates several requester ports onto one asynchronous SRAM, one fixed-length
// access at a time; the data-bus tristate lives above this block.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS     = 3,
    parameter int unsigned ADDR_WIDTH    = DefaultAddrWidth,
    parameter int unsigned DATA_WIDTH    = DefaultDataWidth,
    parameter int unsigned ACCESS_CYCLES = DefaultAccessCycles,
    parameter int unsigned RR_MODE       = 1,
    parameter int unsigned RT_PORT       = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            req,
    input  logic [NUM_PORTS-1:0]            we,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata,
    output logic [NUM_PORTS-1:0]            done,
    output logic [DATA_WIDTH-1:0]           rdata,
    output logic [ADDR_WIDTH-1:0]           sram_addr,
    output logic [DATA_WIDTH-1:0]           sram_dq_out,
    output logic                            sram_dq_oe,
    input  logic [DATA_WIDTH-1:0]           sram_dq_in,
    output logic                            sram_ce_n,
    output logic                            sram_oe_n,
    output logic                            sram_we_n
);

    localparam int unsigned     PtrW     = $clog2(NUM_PORTS);
    localparam int unsigned     CntW     = $clog2(ACCESS_CYCLES) + 1;
    localparam logic [CntW-1:0] CntLoad  = CntW'(ACCESS_CYCLES);
    localparam logic [PtrW-1:0] LastPort = PtrW'(NUM_PORTS - 1);

    arb_state_e            state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [PtrW-1:0]       ptr_q, ptr_d;
    logic [PtrW-1:0]       idx_q, idx_d;
    logic [PtrW-1:0]       win_idx;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [NUM_PORTS-1:0]  done_q, done_d;
    logic [NUM_PORTS-1:0]  eligible, grant;
    logic                  access, last;

    // A port in its done cycle is masked so a held req is not granted twice.
    assign eligible = req & ~done_q;
    assign access   = (state_q == StAccess);
    assign last     = (cnt_q == CntW'(1));

    rr_priority_picker #(
        .NUM_REQ   (NUM_PORTS),
        .PTR_WIDTH (PtrW),
        .RR_MODE   (RR_MODE),
        .RT_INDEX  (RT_PORT)
    ) u_picker (
        .req   (eligible),
        .ptr   (ptr_q),
        .grant (grant)
    );

    always_comb begin
        win_idx = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (grant[i]) begin
                win_idx = PtrW'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        done_d  = '0;
        unique case (state_q)
            StIdle: begin
                if (|eligible) begin
                    state_d = StAccess;
                    cnt_d   = CntLoad;
                    idx_d   = win_idx;
                    we_d    = we[win_idx];
                    addr_d  = addr[32'(win_idx) * ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d = wdata[32'(win_idx) * DATA_WIDTH +: DATA_WIDTH];
                    if (RR_MODE != 0) begin
                        ptr_d = (win_idx == LastPort) ? '0 : win_idx + PtrW'(1);
                    end
                end
            end
            StAccess: begin
                cnt_d = cnt_q - CntW'(1);
                if (last) begin
                    state_d       = StIdle;
                    done_d[idx_q] = 1'b1;
                    if (!we_q) begin
                        rdata_d = sram_dq_in;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ptr_q   <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
        end
    end

    // Strobes decode straight from state so reset releases the bus without waiting for a clock.
    assign done        = done_q;
    assign rdata       = rdata_q;
    assign sram_addr   = addr_q;
    assign sram_dq_out = wdata_q;
    assign sram_ce_n   = !access;
    assign sram_oe_n   = !(access && !we_q);
    assign sram_we_n   = !(access && we_q && !last);
    assign sram_dq_oe  = access && we_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized and directed bench for sram_port_arbiter against a transaction-level model.
module tb_sram_port_arbiter;

    localparam int N  = 3;
    localparam int AW = 20;
    localparam int DW = 32;
    localparam int AC = 2;

    typedef enum int {PIdle, PPend, PHold} port_st_e;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req, we, done;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [DW-1:0]   rdata, sram_dq_out, sram_dq_in;
    logic [AW-1:0]   sram_addr;
    logic            sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;

    sram_port_arbiter #(
        .NUM_PORTS     (N),
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .ACCESS_CYCLES (AC),
        .RR_MODE       (1),
        .RT_PORT       (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .we          (we),
        .addr        (addr),
        .wdata       (wdata),
        .done        (done),
        .rdata       (rdata),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in),
        .sram_ce_n   (sram_ce_n),
        .sram_oe_n   (sram_oe_n),
        .sram_we_n   (sram_we_n)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] sram_word(input logic [AW-1:0] a);
        if (a == 20'h00010) return 32'hDEADBEEF;
        return {a[11:0], a} ^ 32'h5A5A_3C3C;
    endfunction

    assign sram_dq_in = sram_oe_n ? 32'hFFFF_FFFF : sram_word(sram_addr);

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: one access in flight, remaining-cycle count, RR pointer.
    int            m_left = 0;
    int            m_cur  = 0;
    int            m_ptr  = 0;
    logic          m_we   = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_rdata = '0;
    logic [N-1:0]  m_done = '0;

    function automatic int pick(input logic [N-1:0] e, input int ptr);
        if (e[0]) return 0;
        for (int k = 0; k < N; k++) begin
            if (e[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_edge;
        logic [N-1:0] prev_done, elig;
        int w;
        prev_done = m_done;
        m_done    = '0;
        if (!rst) begin
            m_left  = 0;
            m_ptr   = 0;
            m_rdata = '0;
            return;
        end
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_done[m_cur] = 1'b1;
                if (!m_we) m_rdata = sram_word(m_addr);
            end
        end else begin
            elig = req & ~prev_done;
            if (elig != 0) begin
                w       = pick(elig, m_ptr);
                m_cur   = w;
                m_we    = we[w];
                m_addr  = addr[w*AW +: AW];
                m_wdata = wdata[w*DW +: DW];
                m_left  = AC;
                m_ptr   = (w + 1) % N;
            end
        end
    endtask

    // Requesters
    port_st_e      ps [N];
    logic          persist [N];
    logic          p_we [N];
    logic [AW-1:0] p_addr [N];
    logic [DW-1:0] p_wdata [N];
    logic          gen_en = 1'b0;

    task automatic new_fields(input int i);
        p_we[i]    = 1'($urandom_range(0, 1));
        p_addr[i]  = AW'($urandom);
        p_wdata[i] = $urandom;
    endtask

    task automatic pack_ports;
        for (int i = 0; i < N; i++) begin
            req[i]             = (ps[i] != PIdle);
            we[i]              = p_we[i];
            addr[i*AW +: AW]   = p_addr[i];
            wdata[i*DW +: DW]  = p_wdata[i];
            // In-flight inputs may wander; the latched access must not notice.
            if (gen_en && m_left > 0 && m_cur == i && $urandom_range(0, 3) == 0) begin
                we[i]             = ~p_we[i];
                addr[i*AW +: AW]  = AW'($urandom);
                wdata[i*DW +: DW] = $urandom;
            end
        end
    endtask

    task automatic update_ports;
        for (int i = 0; i < N; i++) begin
            case (ps[i])
                PIdle: if (gen_en && $urandom_range(0, 3) == 0) begin
                    ps[i] = PPend;
                    new_fields(i);
                end
                PPend: begin
                    if (m_done[i]) begin
                        if (persist[i]) new_fields(i);
                        else ps[i] = ($urandom_range(0, 1) == 1) ? PHold : PIdle;
                    end else if (gen_en && !(m_left > 0 && m_cur == i)
                                 && $urandom_range(0, 15) == 0) begin
                        ps[i] = PIdle;
                    end
                end
                default: ps[i] = PIdle;
            endcase
        end
        pack_ports();
    endtask

    int cyc = 0;
    int oe_cnt = 0;
    int wen_cnt = 0;
    int log_port[$];
    int log_cyc[$];

    task automatic step;
        logic access;
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        access = (m_left > 0);
        check_eq("done", done, m_done);
        check_eq("rdata", rdata, m_rdata);
        check_eq("ce_n", sram_ce_n, !access);
        check_eq("oe_n", sram_oe_n, !(access && !m_we));
        check_eq("we_n", sram_we_n, !(access && m_we && m_left > 1));
        check_eq("dq_oe", sram_dq_oe, access && m_we);
        if (access) check_eq("sram_addr", sram_addr, m_addr);
        if (access && m_we) check_eq("dq_out", sram_dq_out, m_wdata);
        for (int i = 0; i < N; i++) begin
            if (done[i]) begin
                log_port.push_back(i);
                log_cyc.push_back(cyc);
            end
        end
        if (sram_dq_oe) oe_cnt++;
        if (!sram_we_n) wen_cnt++;
        update_ports();
    endtask

    function automatic logic idle_all();
        for (int i = 0; i < N; i++) if (ps[i] != PIdle) return 1'b0;
        return (m_left == 0);
    endfunction

    task automatic drain;
        gen_en = 1'b0;
        for (int i = 0; i < N; i++) persist[i] = 1'b0;
        for (int k = 0; k < 40 && !idle_all(); k++) step();
        check_eq("drain", idle_all(), 1'b1);
        oe_cnt  = 0;
        wen_cnt = 0;
        log_port.delete();
        log_cyc.delete();
    endtask

    function automatic int lp(input int k);
        return (k < log_port.size()) ? log_port[k] : -1;
    endfunction

    function automatic int gap(input int k);
        return (k < log_cyc.size() && k > 0) ? log_cyc[k] - log_cyc[k-1] : -1;
    endfunction

    initial begin
        int lat;
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            ps[i] = PIdle;
            persist[i] = 1'b0;
            p_we[i] = 1'b0;
            p_addr[i] = '0;
            p_wdata[i] = '0;
        end
        pack_ports();
        #12;
        check_eq("rst_done", done, 0);
        check_eq("rst_rdata", rdata, 0);
        check_eq("rst_ce_n", sram_ce_n, 1);
        check_eq("rst_oe_n", sram_oe_n, 1);
        check_eq("rst_we_n", sram_we_n, 1);
        check_eq("rst_dq_oe", sram_dq_oe, 0);
        check_eq("rst_addr", sram_addr, 0);
        check_eq("rst_dq_out", sram_dq_out, 0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // Single read on port 1
        drain();
        ps[1] = PPend; p_we[1] = 1'b0; p_addr[1] = 20'h00010; p_wdata[1] = '0;
        pack_ports();
        lat = 0;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            step();
            if (done[1]) lat = k;
        end
        check_eq("read_latency", lat, 3);
        check_eq("read_rdata", rdata, 32'hDEADBEEF);
        check_eq("read_we_low", wen_cnt, 0);

        // Single write on port 2
        drain();
        ps[2] = PPend; p_we[2] = 1'b1; p_addr[2] = 20'h00ABC; p_wdata[2] = 32'h12345678;
        pack_ports();
        repeat (6) step();
        check_eq("write_oe_cycles", oe_cnt, 2);
        check_eq("write_we_low_cycles", wen_cnt, 1);
        check_eq("write_done_count", log_port.size(), 1);
        check_eq("write_done_port", lp(0), 2);

        // Reset in the second ACCESS cycle of a write; the held req is served afterwards
        drain();
        ps[2] = PPend; p_we[2] = 1'b1; p_addr[2] = 20'h00321; p_wdata[2] = 32'hCAFEF00D;
        pack_ports();
        step();
        step();
        #2 rst = 1'b0;
        #1;
        check_eq("abort_dq_oe", sram_dq_oe, 0);
        check_eq("abort_ce_n", sram_ce_n, 1);
        check_eq("abort_oe_n", sram_oe_n, 1);
        check_eq("abort_we_n", sram_we_n, 1);
        check_eq("abort_done", done, 0);
        m_left = 0; m_done = '0; m_ptr = 0; m_rdata = '0;
        log_port.delete();
        log_cyc.delete();
        repeat (2) step();
        #2 rst = 1'b1;
        repeat (6) step();
        check_eq("reserve_count", log_port.size(), 1);
        check_eq("reserve_port", lp(0), 2);

        // Ports 1 and 2 requesting continuously alternate
        drain();
        persist[1] = 1'b1; persist[2] = 1'b1;
        ps[1] = PPend; ps[2] = PPend;
        new_fields(1);
        new_fields(2);
        pack_ports();
        repeat (12) step();
        check_eq("rr_count_ge4", log_port.size() >= 4, 1);
        check_eq("rr_first", lp(0) == 1 || lp(0) == 2, 1);
        for (int k = 1; k < 4; k++) begin
            check_eq("rr_alternate", lp(k), (lp(k-1) == 1) ? 2 : 1);
            check_eq("rr_gap", gap(k), AC + 1);
        end

        // Real-time port 0 jumps the queue, then the pointer sits at 1
        for (int k = 0; k < 6 && m_done == 0; k++) step();
        log_port.delete();
        log_cyc.delete();
        ps[0] = PPend;
        new_fields(0);
        pack_ports();
        repeat (8) step();
        check_eq("rt_first", lp(0), 0);
        check_eq("rt_then_port1", lp(1), 1);
        check_eq("rt_gap", gap(1), AC + 1);

        // Port 1 alone holding req through done: one extra cycle before re-grant
        drain();
        persist[1] = 1'b1;
        ps[1] = PPend;
        new_fields(1);
        pack_ports();
        repeat (14) step();
        check_eq("hold_count_ge3", log_port.size() >= 3, 1);
        check_eq("hold_gap1", gap(1), AC + 2);
        check_eq("hold_gap2", gap(2), AC + 2);

        // Random traffic
        drain();
        gen_en = 1'b1;
        repeat (3000) step();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 3: number of requester ports, legal range 2..8.
REQ-002 Parameter ADDR_WIDTH, default 20: SRAM word-address width.
REQ-003 Parameter DATA_WIDTH, default 32: SRAM data width.
REQ-004 Parameter ACCESS_CYCLES, default 2: bus cycles per SRAM access, legal range 1..8.
REQ-005 Parameter RR_MODE, default 1: 1 selects round-robin arbitration; 0 selects fixed priority, where the lowest index wins.
REQ-006 Parameter RT_PORT, default 0: real-time (display-fetch) port that wins over all others whenever it requests.
REQ-007 clk  in  1  single clock domain; all logic is synchronous to its rising edge.
REQ-008 rst  in  1  asynchronous, active-low reset.
REQ-009 req  in  NUM_PORTS  per-port access request.
REQ-010 we  in  NUM_PORTS  per-port write enable; 1 = write, 0 = read.
REQ-011 addr  in  NUM_PORTS x ADDR_WIDTH  per-port address.
REQ-012 wdata  in  NUM_PORTS x DATA_WIDTH  per-port write data.
REQ-013 done  out  NUM_PORTS  one-cycle completion pulse per port.
REQ-014 rdata  out  DATA_WIDTH  read data, shared by all ports; valid in a port's done cycle.
REQ-015 sram_addr  out  ADDR_WIDTH  SRAM address.
REQ-016 sram_dq_out  out  DATA_WIDTH  SRAM write data.
REQ-017 sram_dq_oe  out  1  data-bus drive enable, consumed by the top-level tristate.
REQ-018 sram_dq_in  in  DATA_WIDTH  SRAM read data.
REQ-019 sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low SRAM strobes.

Function
REQ-020 The state machine SHALL have two states, IDLE and ACCESS.
REQ-021 In IDLE, when any unmasked req is high at a rising edge, the arbiter SHALL latch the winner's index, we, addr and wdata, and enter ACCESS.
REQ-022 Winner selection: RT_PORT if it requests; otherwise, when RR_MODE=1, the first requesting port at or after rr_ptr (cyclic); otherwise, when RR_MODE=0, the lowest requesting index.
REQ-023 When RR_MODE=1, rr_ptr SHALL become (winner+1) mod NUM_PORTS on each grant, including RT_PORT grants.
REQ-024 ACCESS SHALL last exactly ACCESS_CYCLES cycles, counted by a down-counter of clog2(ACCESS_CYCLES)+1 bits.
REQ-025 Outputs during ACCESS:
- sram_ce_n SHALL be 0 and sram_addr SHALL hold the latched address.
- Read: sram_oe_n=0, sram_we_n=1, sram_dq_oe=0.
- Write: sram_oe_n=1, sram_dq_oe=1, sram_dq_out holds the latched wdata, and sram_we_n=0 in every ACCESS cycle except the last (data hold).
REQ-026 At the edge ending the final ACCESS cycle, the arbiter SHALL assert done[winner] for exactly one cycle and return to IDLE. On a read it SHALL also register sram_dq_in into rdata.
REQ-027 rdata SHALL hold its value until the next read completes.
REQ-028 Latency from the sampling edge of req to done high SHALL be ACCESS_CYCLES+1 cycles; the maximum throughput SHALL be one access per ACCESS_CYCLES+1 cycles.
REQ-029 In the cycle where done[i] is high, req[i] SHALL be masked from arbitration, so a port holding req through its done cycle is not re-granted spuriously.
REQ-030 Requesters SHALL hold req, we, addr and wdata stable until their done pulse; changes to these inputs during ACCESS SHALL have no effect on the access in flight.
REQ-031 A req withdrawn before it is granted SHALL be dropped without any bus activity.
REQ-032 In IDLE the arbiter SHALL drive sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_dq_oe=0.
REQ-033 Simultaneous requests SHALL produce exactly one grant; the losing ports wait with no request lost.

Reset
REQ-034 While rst=0, the arbiter SHALL force IDLE, rr_ptr=0, counter=0, done=0, rdata=0, sram_ce_n/oe_n/we_n=1, sram_dq_oe=0, and sram_addr and sram_dq_out to 0.
REQ-035 Reset asserted mid-ACCESS SHALL abort the access with no done pulse; sram_dq_oe SHALL drop asynchronously.
REQ-036 After rst deasserts, the first grant SHALL occur no earlier than the first rising edge on which rst is already high.

Structure
REQ-037 The shared package SHALL hold the SramAddress/SramData typedefs, the arbiter state enum, and the default ACCESS_CYCLES constant.
REQ-038 One sub-module, rr_priority_picker (parametrised request vector, pointer, RT index; combinational one-hot winner), SHALL implement the selection logic.
REQ-039 The tristate SHALL remain at the top level; this block SHALL contain no inout ports.

Verification
REQ-040 Single read, ACCESS_CYCLES=2: req[1] with addr 0x00010 and sram_dq_in=0xDEADBEEF -> done[1] 3 cycles after the sampling edge, rdata=0xDEADBEEF, sram_we_n never 0.
REQ-041 Write, port 2, wdata 0x12345678: sram_dq_oe=1 for 2 cycles, sram_we_n=0 for 1 cycle, done[2] pulses once.
REQ-042 RR_MODE=1, ports 1 and 2 requesting continuously: grants alternate 1,2,1,2 with no starvation and one idle cycle between accesses.
REQ-043 RT_PORT=0 raised while ports 1 and 2 wait: port 0 wins the next arbitration, and rr_ptr advances to 1.
REQ-044 rst pulled low in the 2nd ACCESS cycle of a write: sram_dq_oe=0 and all strobes=1 immediately, no done pulse; after release, a held req is re-served.
REQ-045 req[1] held through done[1]: no re-grant in the done cycle; the next grant occurs 1 cycle later.
